// File: rtl/branch_gshare_ctrl_if.sv
// -----------------------------------------------------------------------------
// branch_gshare_ctrl_if
// Groups the fetch-side lookup signals and the execute-side training signals
// of the gshare predictor into one bundle.
//   pred_pc, pred_valid             : fetch lookup request (master -> slave)
//   prediction, pred_index          : same-cycle lookup result (slave -> master)
//   upd_valid, upd_index, upd_taken : resolved-branch training (master -> slave)
//   ready                           : table initialised, predictor live
// master = fetch/execute pipeline, slave = predictor.
// -----------------------------------------------------------------------------
interface branch_gshare_ctrl_if #(
  parameter int INDEX_BITS = 6,
  parameter int PC_WIDTH   = 32
);
  logic [PC_WIDTH-1:0]   pred_pc;
  logic                  pred_valid;
  logic                  prediction;
  logic [INDEX_BITS-1:0] pred_index;
  logic                  upd_valid;
  logic [INDEX_BITS-1:0] upd_index;
  logic                  upd_taken;
  logic                  ready;

  modport master (
    output pred_pc, pred_valid, upd_valid, upd_index, upd_taken,
    input  prediction, pred_index, ready
  );

  modport slave (
    input  pred_pc, pred_valid, upd_valid, upd_index, upd_taken,
    output prediction, pred_index, ready
  );
endinterface

// File: rtl/branch_gshare_ctrl.sv
// -----------------------------------------------------------------------------
// branch_gshare_ctrl
// Gshare branch predictor controller. Holds a table of 2-bit saturating
// counters indexed by PC[INDEX_BITS+1:2] XOR the global history register.
// After reset it sweeps the table to weakly-not-taken, then goes live.
// Ports:
//   clk   : clock, all state changes on posedge
//   reset : synchronous, active-high
//   bus   : slave side of branch_gshare_ctrl_if (lookup, training, ready)
// Lookups are combinational and read-before-write against a same-cycle update.
// -----------------------------------------------------------------------------
module branch_gshare_ctrl #(
  parameter int INDEX_BITS = 6,
  parameter int GHR_BITS   = 6,
  parameter int PC_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  branch_gshare_ctrl_if.slave  bus
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  localparam logic [1:0] CNT_SNT = 2'b00;
  localparam logic [1:0] CNT_WNT = 2'b01;
  localparam logic [1:0] CNT_WT  = 2'b10;
  localparam logic [1:0] CNT_ST  = 2'b11;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // One saturating step of a 2-bit direction counter.
  function automatic logic [1:0] sat_step(input logic [1:0] cnt, input logic taken);
    logic [1:0] nxt;
    case (cnt)
      CNT_SNT: nxt = taken ? CNT_WNT : CNT_SNT;
      CNT_WNT: nxt = taken ? CNT_WT  : CNT_SNT;
      CNT_WT:  nxt = taken ? CNT_ST  : CNT_WNT;
      CNT_ST:  nxt = taken ? CNT_ST  : CNT_WT;
      default: nxt = CNT_WNT;
    endcase
    return nxt;
  endfunction

  state_t                state_q;
  logic [INDEX_BITS-1:0] init_ptr_q;
  logic [GHR_BITS-1:0]   ghr_q;
  logic [GHR_BITS-1:0]   ghr_d;
  logic                  ready_q;
  logic [1:0]            pht_q [ENTRIES];

  logic [INDEX_BITS-1:0] ghr_ext_s;
  logic [INDEX_BITS-1:0] pred_index_s;
  logic                  prediction_s;
  logic                  upd_accept_s;
  logic                  pht_we_s;
  logic [INDEX_BITS-1:0] pht_waddr_s;
  logic [1:0]            pht_wdata_s;
  logic                  unused_pc_s;

  // PC bits outside the index field and the byte offset do not affect the hash.
  assign unused_pc_s = ^{bus.pred_pc[1:0], bus.pred_pc[PC_WIDTH-1:INDEX_BITS+2]};

  // Training is only honoured once the table is live and not under reset.
  assign upd_accept_s = (state_q == ST_RUN) && bus.upd_valid && !reset;

  // History shift: newest outcome enters at the LSB; a 1-bit history is just the last outcome.
  generate
    if (GHR_BITS == 1) begin : g_ghr1
      assign ghr_d = bus.upd_taken;
    end else begin : g_ghrn
      assign ghr_d = {ghr_q[GHR_BITS-2:0], bus.upd_taken};
    end
  endgenerate

  // Zero-extend the history to index width and hash it with the PC.
  always_comb begin
    ghr_ext_s                 = '0;
    ghr_ext_s[GHR_BITS-1:0]   = ghr_q;
    pred_index_s              = bus.pred_pc[INDEX_BITS+1:2] ^ ghr_ext_s;
  end

  // Lookup reads the registered table, so a same-cycle update is not yet visible.
  always_comb begin
    prediction_s = 1'b0;
    if ((state_q == ST_RUN) && bus.pred_valid) begin
      prediction_s = pht_q[pred_index_s][1];
    end else begin
      prediction_s = 1'b0;
    end
  end

  // Select the single table write for this cycle: init sweep or a training step.
  always_comb begin
    pht_we_s    = 1'b0;
    pht_waddr_s = init_ptr_q;
    pht_wdata_s = CNT_WNT;
    if (reset) begin
      pht_we_s = 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          pht_we_s    = 1'b1;
          pht_waddr_s = init_ptr_q;
          pht_wdata_s = CNT_WNT;
        end
        ST_RUN: begin
          if (bus.upd_valid) begin
            pht_we_s    = 1'b1;
            pht_waddr_s = bus.upd_index;
            pht_wdata_s = sat_step(pht_q[bus.upd_index], bus.upd_taken);
          end else begin
            pht_we_s = 1'b0;
          end
        end
        default: pht_we_s = 1'b0;
      endcase
    end
  end

  // Init/run controller with init pointer, history register and registered ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_INIT;
      init_ptr_q <= '0;
      ghr_q      <= '0;
      ready_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          init_ptr_q <= init_ptr_q + {{(INDEX_BITS-1){1'b0}}, 1'b1};
          if (init_ptr_q == {INDEX_BITS{1'b1}}) begin
            state_q <= ST_RUN;
            ready_q <= 1'b1;
          end else begin
            state_q <= ST_INIT;
            ready_q <= 1'b0;
          end
        end
        ST_RUN: begin
          ready_q <= 1'b1;
          if (upd_accept_s) begin
            ghr_q <= ghr_d;
          end
        end
        default: begin
          state_q    <= ST_INIT;
          init_ptr_q <= '0;
          ready_q    <= 1'b0;
        end
      endcase
    end
  end

  // Pattern history table storage; contents are only meaningful after the init sweep.
  always_ff @(posedge clk) begin
    if (pht_we_s) begin
      pht_q[pht_waddr_s] <= pht_wdata_s;
    end
  end

  assign bus.prediction = prediction_s;
  assign bus.pred_index = pred_index_s;
  assign bus.ready      = ready_q;

endmodule

// File: tb/tb_branch_gshare_ctrl.sv
module tb_branch_gshare_ctrl;

  localparam int IB = 6;
  localparam int PW = 32;
  localparam int N  = 1 << IB;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  branch_gshare_ctrl_if #(.INDEX_BITS(IB), .PC_WIDTH(PW)) bus ();

  branch_gshare_ctrl #(.INDEX_BITS(IB), .GHR_BITS(6), .PC_WIDTH(PW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  logic [1:0] model_pht [N];
  logic [5:0] model_ghr;
  logic       model_run;
  logic [6:0] exp_q [$];

  function automatic logic [1:0] model_step(input logic [1:0] c, input logic tk);
    if (tk) return (c == 2'd3) ? 2'd3 : c + 2'd1;
    else    return (c == 2'd0) ? 2'd0 : c - 2'd1;
  endfunction

  function automatic logic [31:0] pc_for_index(input logic [5:0] idx);
    logic [5:0] f;
    f = idx ^ model_ghr;
    return {24'h0, f, 2'b00};
  endfunction

  // Lookup: push model expectation, let the combinational result settle, pop and compare.
  task automatic lookup_pc(input logic [31:0] pc, input logic pv, input string name);
    logic [5:0] idx;
    logic [6:0] e;
    logic [6:0] got;
    @(negedge clk);
    bus.pred_pc    = pc;
    bus.pred_valid = pv;
    idx = pc[7:2] ^ model_ghr;
    exp_q.push_back({model_run & pv & model_pht[idx][1], idx});
    #1;
    got = {bus.prediction, bus.pred_index};
    e   = exp_q.pop_front();
    tests_run++;
    if (got !== e) begin
      tests_failed++;
      $display("FAIL %s: got pred=%0b idx=%0d, expected pred=%0b idx=%0d",
               name, got[6], got[5:0], e[6], e[5:0]);
    end
  endtask

  task automatic lookup(input logic [5:0] idx, input logic pv, input string name);
    lookup_pc(pc_for_index(idx), pv, name);
  endtask

  task automatic apply_update(input logic [5:0] idx, input logic tk);
    @(negedge clk);
    bus.upd_valid = 1'b1;
    bus.upd_index = idx;
    bus.upd_taken = tk;
    @(posedge clk);
    if (model_run) begin
      model_pht[idx] = model_step(model_pht[idx], tk);
      model_ghr      = {model_ghr[4:0], tk};
    end
    #1;
    bus.upd_valid = 1'b0;
  endtask

  task automatic check_cnt(input logic [5:0] idx, input logic [1:0] req, input string name);
    tests_run++;
    if (dut.pht_q[idx] !== req) begin
      tests_failed++;
      $display("FAIL %s: pht[%0d]=%0b required %0b", name, idx, dut.pht_q[idx], req);
    end
  endtask

  task automatic check_ghr(input logic [5:0] req, input string name);
    tests_run++;
    if (dut.ghr_q !== req) begin
      tests_failed++;
      $display("FAIL %s: ghr=%b required %b", name, dut.ghr_q, req);
    end
  endtask

  task automatic check_ready(input logic req, input string name);
    tests_run++;
    if (bus.ready !== req) begin
      tests_failed++;
      $display("FAIL %s: ready=%0b required %0b", name, bus.ready, req);
    end
  endtask

  // Count edges from reset release until ready; must be exactly N.
  task automatic wait_ready(input string name);
    int cnt;
    cnt = 0;
    while (bus.ready !== 1'b1 && cnt < 200) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    tests_run++;
    if (cnt != N) begin
      tests_failed++;
      $display("FAIL %s: init took %0d cycles, required %0d", name, cnt, N);
    end
    for (int i = 0; i < N; i++) model_pht[i] = 2'b01;
    model_run = 1'b1;
  endtask

  task automatic pulse_reset(input int cycles, input string name);
    @(negedge clk);
    reset          = 1'b1;
    bus.pred_valid = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    model_run = 1'b0;
    model_ghr = 6'd0;
    check_ready(1'b0, {name, "_ready"});
    check_ghr(6'd0, {name, "_ghr"});
    tests_run++;
    if (bus.prediction !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_pred: prediction=%0b required 0", name, bus.prediction);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset;
    pulse_reset(2, "reset");
    wait_ready("init_sweep");
    for (int i = 0; i < N; i++) check_cnt(i[5:0], 2'b01, "init_wnt");
    for (int i = 0; i < N; i++) lookup(i[5:0], 1'b1, "init_pred");
  endtask

  task automatic test_training;
    apply_update(6'd5, 1'b1);
    check_cnt(6'd5, 2'b10, "train_wt");
    lookup(6'd5, 1'b1, "train_wt_pred");
    tests_run++;
    if (bus.prediction !== 1'b1) begin
      tests_failed++;
      $display("FAIL train_wt_pred_const: prediction=%0b required 1", bus.prediction);
    end
    repeat (2) apply_update(6'd5, 1'b1);
    check_cnt(6'd5, 2'b11, "train_st");
    repeat (5) apply_update(6'd5, 1'b1);
    check_cnt(6'd5, 2'b11, "train_st_sat");
    lookup(6'd5, 1'b1, "train_st_pred");
    repeat (2) apply_update(6'd5, 1'b0);
    check_cnt(6'd5, 2'b01, "train_back_wnt");
    lookup(6'd5, 1'b1, "train_wnt_pred");
    check_ghr(6'b111100, "train_ghr");
  endtask

  task automatic test_ghr;
    pulse_reset(1, "ghr_reset");
    wait_ready("ghr_init");
    apply_update(6'd0, 1'b1);
    apply_update(6'd0, 1'b0);
    apply_update(6'd0, 1'b1);
    check_ghr(6'b000101, "ghr_pattern");
    lookup_pc(32'h0000_0000, 1'b1, "ghr_idx_pc0");
    tests_run++;
    if (bus.pred_index !== 6'd5) begin
      tests_failed++;
      $display("FAIL ghr_idx_pc0_const: pred_index=%0d required 5", bus.pred_index);
    end
    lookup_pc(32'h0000_0014, 1'b1, "ghr_idx_pc14");
    tests_run++;
    if (bus.pred_index !== 6'd0) begin
      tests_failed++;
      $display("FAIL ghr_idx_pc14_const: pred_index=%0d required 0", bus.pred_index);
    end
  endtask

  task automatic test_rbw;
    logic [6:0] e;
    logic [6:0] got;
    check_cnt(6'd9, 2'b01, "rbw_pre");
    @(negedge clk);
    bus.pred_pc    = pc_for_index(6'd9);
    bus.pred_valid = 1'b1;
    bus.upd_valid  = 1'b1;
    bus.upd_index  = 6'd9;
    bus.upd_taken  = 1'b1;
    exp_q.push_back({model_pht[9][1], 6'd9});
    #1;
    got = {bus.prediction, bus.pred_index};
    e   = exp_q.pop_front();
    tests_run++;
    if (got !== e || got[6] !== 1'b0) begin
      tests_failed++;
      $display("FAIL rbw_same: got pred=%0b idx=%0d, expected pred=%0b idx=%0d",
               got[6], got[5:0], e[6], e[5:0]);
    end
    @(posedge clk);
    model_pht[9] = model_step(model_pht[9], 1'b1);
    model_ghr    = {model_ghr[4:0], 1'b1};
    #1;
    bus.upd_valid = 1'b0;
    lookup(6'd9, 1'b1, "rbw_next");
    tests_run++;
    if (bus.prediction !== 1'b1) begin
      tests_failed++;
      $display("FAIL rbw_next_const: prediction=%0b required 1", bus.prediction);
    end
  endtask

  task automatic test_back_to_back;
    logic [5:0] idx;
    logic       tk;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      idx = 6'($urandom_range(0, 63));
      tk  = 1'($urandom);
      bus.upd_valid = 1'b1;
      bus.upd_index = idx;
      bus.upd_taken = tk;
      @(posedge clk);
      model_pht[idx] = model_step(model_pht[idx], tk);
      model_ghr      = {model_ghr[4:0], tk};
    end
    @(negedge clk);
    bus.upd_valid = 1'b0;
    check_ghr(model_ghr, "b2b_ghr");
    for (int i = 0; i < N; i++) check_cnt(i[5:0], model_pht[i], "b2b_pht");
    for (int i = 0; i < 8; i++) lookup(6'($urandom_range(0, 63)), 1'b1, "b2b_pred");
  endtask

  task automatic test_reset_mid_run;
    repeat (3) apply_update(6'd3, 1'b1);
    check_cnt(6'd3, 2'b11, "midrun_st");
    pulse_reset(1, "midrun_reset");
    wait_ready("midrun_init");
    check_cnt(6'd3, 2'b01, "midrun_wnt");
    lookup(6'd3, 1'b1, "midrun_pred");
  endtask

  task automatic test_init_update;
    pulse_reset(1, "init_reset");
    repeat (20) @(posedge clk);
    apply_update(6'd0, 1'b1);
    apply_update(6'd0, 1'b1);
    check_ghr(6'd0, "init_upd_ghr");
    check_cnt(6'd0, 2'b01, "init_upd_pht");
    check_ready(1'b0, "init_upd_ready");
    lookup(6'd0, 1'b1, "init_pred_zero");
    repeat (6) @(posedge clk);
    pulse_reset(1, "init_mid_reset");
    wait_ready("init_restart");
    repeat (3) apply_update(6'd7, 1'b1);
    check_cnt(6'd7, 2'b11, "pv0_st");
    lookup(6'd7, 1'b0, "pv0_pred");
    tests_run++;
    if (bus.prediction !== 1'b0) begin
      tests_failed++;
      $display("FAIL pv0_const: prediction=%0b required 0", bus.prediction);
    end
    lookup(6'd7, 1'b1, "pv1_pred");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b1;
    bus.pred_pc    = 32'h0;
    bus.pred_valid = 1'b0;
    bus.upd_valid  = 1'b0;
    bus.upd_index  = 6'd0;
    bus.upd_taken  = 1'b0;
    model_run      = 1'b0;
    model_ghr      = 6'd0;
    for (int i = 0; i < N; i++) model_pht[i] = 2'b01;
    repeat (2) @(posedge clk);

    test_reset();
    test_training();
    test_ghr();
    test_rbw();
    test_back_to_back();
    test_reset_mid_run();
    test_init_update();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
